elbeth_lsu: RTL and testbench
=============================

Name: elbeth_lsu

Overview:
Load/store unit sitting directly upstream of data port B of elbeth_memory. It accepts one byte, half or word access at a time from the core's memory stage. It translates byte addresses into word address plus byte-lane write strobes, replicates store data across lanes, and issues a single-cycle memory enable. It then waits for the memory's ready, and extracts, aligns and sign/zero-extends load data. Misaligned, bad-size, out-of-range and timed-out accesses are reported as errors.

Parameters:
AW, 8, memory word-address width (memory depth 2**AW words).
TIMEOUT, 15, max cycles in WAIT before a timeout error; minimum value 1.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
req_valid  input  1  access request; sampled only when req_ready=1
req_ready  output  1  combinational, 1 iff state==IDLE
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  2  00 ok, 01 misaligned/bad size, 10 out of range, 11 timeout
mem_enable  output  1  to bmem_enable
mem_addr  output  AW  to bmem_addr, word address
mem_data_in  output  32  to bmem_data_in
mem_wr  output  4  to bmem_wr, byte-lane strobes
mem_data_out  input  32  from bmem_data_out
mem_ready  input  1  from bmem_ready

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs except req_ready are registered.
- Reset (rst=0, async): state=IDLE; mem_enable, mem_addr, mem_data_in, mem_wr, resp_valid, resp_rdata, resp_err and the timeout counter all 0. req_ready=1.
- Error checks in IDLE (req_valid=1), in priority order:
  - req_size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> err 01.
  - addr[31:AW+2]!=0 -> err 10.
  - On error: no memory access; next state RESP with the error latched.
- IDLE, valid, no error -> REQ:
  - mem_addr=req_addr[AW+1:2].
  - Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Loads: mem_wr=0000.
  - Latch addr[1:0], size, unsigned, we.
- REQ: mem_enable=1 for exactly one cycle (the memory writes at the closing edge), then WAIT. Counter cleared.
- Leaving REQ clears mem_enable and mem_wr to 0. mem_addr and mem_data_in hold their values.
- WAIT: if mem_ready=1, capture and format mem_data_out, err 00, next state RESP.
  - Otherwise increment the counter. On reaching TIMEOUT: err 11, rdata 0, RESP.
- Load formatting: lane = mem_data_out >> (8*addr[1:0]).
  - Byte: extend lane[7:0]. Half: extend lane[15:0]. Word: as-is.
  - Extension is sign or zero per the latched unsigned bit.
- Stores return rdata 0 and err 00 once mem_ready is seen.
- RESP: resp_valid=1 for one cycle with rdata/err, then IDLE. resp_rdata/resp_err hold until the next RESP.
- Timing for a good access: accept at edge 0 -> REQ cycle 1 -> WAIT cycle 2 (memory ready) -> resp_valid in cycle 3. Throughput is one access per 4 cycles.
- Error path: accept -> resp_valid in the next cycle.
- req_valid outside IDLE is ignored; the requester holds it until req_ready=1.
- Reset during REQ or WAIT: immediate return to IDLE, no resp_valid. A store whose enable edge already occurred stays written.

Test Plan:
- Word store 0x8091A2B3 at addr 0x10 -> REQ cycle shows mem_addr=4, mem_wr=1111, mem_data_in=0x8091A2B3, mem_enable=1 for one cycle; resp_valid 3 cycles after accept, err 00, rdata 0.
- Byte load addr 0x11, signed -> 0xFFFFFFA2; same load unsigned -> 0x000000A2; req_ready low for 3 cycles after each accept.
- Half store 0xBEEF at 0x12 -> mem_data_in=0xBEEFBEEF, mem_wr=1100; then word load at 0x10 -> 0xBEEFA2B3; signed half load at 0x12 -> 0xFFFFBEEF.
- Misaligned word at 0x13 -> no mem_enable, resp_valid next cycle, err 01. Size 11 -> err 01. Addr 0x400 with AW=8 -> err 10.
- Hold mem_ready=0 with TIMEOUT=15 -> resp_valid with err 11, rdata 0, 15 cycles after entering WAIT; next request is accepted normally.
- Assert rst=0 during WAIT -> all outputs 0 asynchronously, req_ready=1, no resp_valid; after release, word load at 0x10 -> 0xBEEFA2B3.

Source files
------------

// File: rtl/elbeth_lsu.sv
// Load/store unit in front of elbeth_memory port B: byte/half/word accesses,
// lane strobes, store replication, load alignment/extension and error reporting.
module elbeth_lsu #(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,

    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic [1:0]    resp_err,

    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_in,
    output logic [3:0]    mem_wr,
    input  logic [31:0]   mem_data_out,
    input  logic          mem_ready
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrRange   = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          we_q, we_d;

    logic          mem_enable_q, mem_enable_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_in_q, mem_data_in_d;
    logic [3:0]    mem_wr_q, mem_wr_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]    resp_err_q, resp_err_d;

    logic          align_err;
    logic          range_err;
    logic [31:0]   wdata_rep;
    logic [3:0]    strb;
    logic [31:0]   lane;
    logic [31:0]   load_data;

    // Request decode: alignment, range, replicated store data and lane strobes
    always_comb begin
        align_err = 1'b0;
        wdata_rep = req_wdata;
        strb      = 4'b0000;
        unique case (req_size)
            SzByte: begin
                wdata_rep = {4{req_wdata[7:0]}};
                strb      = 4'b0001 << req_addr[1:0];
            end
            SzHalf: begin
                align_err = req_addr[0];
                wdata_rep = {2{req_wdata[15:0]}};
                strb      = 4'b0011 << req_addr[1:0];
            end
            SzWord: begin
                align_err = |req_addr[1:0];
                strb      = 4'b1111;
            end
            default: begin
                align_err = 1'b1;
            end
        endcase
        range_err = |(req_addr >> (AW + 2));
    end

    // Load alignment and sign/zero extension from the latched request
    always_comb begin
        lane      = mem_data_out >> {addr_lo_q, 3'b000};
        load_data = lane;
        unique case (size_q)
            SzByte:  load_data = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SzHalf:  load_data = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_lo_d     = addr_lo_q;
        size_d        = size_q;
        uns_d         = uns_q;
        we_d          = we_q;
        mem_enable_d  = mem_enable_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_wr_d      = mem_wr_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (align_err) begin
                        resp_err_d   = ErrAlign;
                        resp_rdata_d = 32'b0;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end else if (range_err) begin
                        resp_err_d   = ErrRange;
                        resp_rdata_d = 32'b0;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end else begin
                        mem_enable_d  = 1'b1;
                        mem_addr_d    = req_addr[AW+1:2];
                        mem_data_in_d = wdata_rep;
                        mem_wr_d      = req_we ? strb : 4'b0000;
                        addr_lo_d     = req_addr[1:0];
                        size_d        = req_size;
                        uns_d         = req_unsigned;
                        we_d          = req_we;
                        state_d       = StReq;
                    end
                end
            end
            StReq: begin
                // Memory commits the access on the edge that closes this cycle
                mem_enable_d = 1'b0;
                mem_wr_d     = 4'b0000;
                cnt_d        = '0;
                state_d      = StWait;
            end
            StWait: begin
                if (mem_ready) begin
                    resp_rdata_d = we_q ? 32'b0 : load_data;
                    resp_err_d   = ErrNone;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CntLast) begin
                        resp_rdata_d = 32'b0;
                        resp_err_d   = ErrTimeout;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_lo_q     <= 2'b00;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            we_q          <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= 32'b0;
            mem_wr_q      <= 4'b0000;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'b0;
            resp_err_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_lo_q     <= addr_lo_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            we_q          <= we_d;
            mem_enable_q  <= mem_enable_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_q      <= mem_wr_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_enable  = mem_enable_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_elbeth_lsu.sv
// Bench for elbeth_lsu: vector table with a response scoreboard and a behavioural
// memory, plus hand sequences for timeout and mid-access reset.
module tb_elbeth_lsu;

    localparam int unsigned AW      = 8;
    localparam int unsigned TIMEOUT = 15;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [1:0]    resp_err;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [3:0]    mem_wr;
    logic [31:0]   mem_data_out;
    logic          mem_ready;

    elbeth_lsu #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_enable   (mem_enable),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural memory: one-cycle access, ready the cycle after enable
    logic [31:0] mem [0:255];
    logic [31:0] mem_w;
    bit          ready_en = 1'b1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'b0;
        mem_ready    = 1'b0;
        mem_data_out = 32'b0;
    end

    always @(posedge clk) begin
        if (mem_enable) begin
            mem_data_out <= mem[mem_addr];
            mem_w = mem[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_wr[i]) mem_w[8*i +: 8] = mem_data_in[8*i +: 8];
            mem[mem_addr] <= mem_w;
            mem_ready     <= ready_en;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)",
                         $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {30'b0, resp_err}, {30'b0, e.err});
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        logic [7:0]  exp_maddr;
        logic [3:0]  exp_wr;
        logic [31:0] exp_din;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [1:0] err,
                                input logic [7:0] maddr, input logic [3:0] wr,
                                input logic [31:0] din);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_maddr = maddr;
        v.exp_wr = wr; v.exp_din = din;
        return v;
    endfunction

    task automatic wait_idle();
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("idle_wait", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int exp_lat);
        int lat, en_cnt, rdy_low;
        bit mem_access;
        mem_access = (v.exp_err == 2'b00) || (v.exp_err == 2'b11);
        wait_idle();
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (mem_access) begin
            check("mem_addr", {24'b0, mem_addr}, {24'b0, v.exp_maddr});
            check("mem_wr", {28'b0, mem_wr}, {28'b0, v.exp_wr});
            if (v.we) check("mem_data_in", mem_data_in, v.exp_din);
        end
        lat = 1; en_cnt = 0; rdy_low = 0;
        while (1) begin
            if (mem_enable) en_cnt++;
            if (!req_ready) rdy_low++;
            if (resp_valid || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("mem_enable_cycles", en_cnt, mem_access ? 1 : 0);
        check("ready_low_cycles", rdy_low, exp_lat);
        @(negedge clk);
        check("ready_after", {31'b0, req_ready}, 32'd1);
        check("rdata_hold", resp_rdata, v.exp_rdata);
        check("mem_wr_cleared", {28'b0, mem_wr}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"}, {30'b0, resp_err}, 32'd0);
        check({tag, "_mem_enable"}, {31'b0, mem_enable}, 32'd0);
        check({tag, "_mem_addr"}, {24'b0, mem_addr}, 32'd0);
        check({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        check({tag, "_mem_wr"}, {28'b0, mem_wr}, 32'd0);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        //           we    sz     u     addr          wdata         rdata         err    ma     wr       din
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h8091A2B3, 32'h0, 2'b00, 8'h04, 4'b1111, 32'h8091A2B3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFA2, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000A2, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'h0, 2'b00, 8'h04, 4'b1100, 32'hBEEFBEEF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFA2B3, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFBEEF, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000BEEF, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFBE, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFA2B3, 2'b00, 8'h04, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A, 32'h0, 2'b00, 8'h08, 4'b0010, 32'h5A5A5A5A));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00005A00, 2'b00, 8'h08, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000005A, 2'b00, 8'h08, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000000, 2'b00, 8'h08, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h13, 32'h11111111, 32'h0, 2'b01, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 2'b01, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 2'b01, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 2'b10, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h80000000, 32'hFF, 32'h0, 2'b10, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 32'h0, 2'b01, 8'h00, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0, 2'b00, 8'hFF, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h000000CA, 2'b00, 8'hFF, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 32'hFFFFFFCA, 2'b00, 8'hFF, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h3FC, 32'h0, 32'hFFFFF00D, 2'b00, 8'hFF, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 2'b00, 8'hFF, 4'b0000, 32'h0));

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'b0;
        req_wdata    = 32'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], (vecs[i].exp_err == 2'b00) ? 3 : 1);

        // Timeout: memory never answers; response lands 15 cycles into WAIT
        ready_en = 1'b0;
        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2'b11, 8'h04, 4'b0000, 32'h0),
                2 + TIMEOUT);
        ready_en = 1'b1;
        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFA2B3, 2'b00, 8'h04, 4'b0000, 32'h0), 3);

        // Reset while waiting on the memory: no response, clean restart
        ready_en = 1'b0;
        wait_idle();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("in_wait_ready", {31'b0, req_ready}, 32'd0);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        ready_en = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_ready", {31'b0, req_ready}, 32'd1);
        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFA2B3, 2'b00, 8'h04, 4'b0000, 32'h0), 3);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
